// File: rtl/shift_arbiter.sv
// Two-requester arbiter that shares one 11-bit logical-left barrel shifter and registers the result.
// Optional macro SHIFT_ARB_ROUND_ROBIN_EN: round-robin tie break (default build: requester 0 wins ties).

module barrelShifter (
  input  logic [10:0] ip,
  input  logic [4:0]  mag,
  output logic [10:0] op
);
  // Shifts of 11 or more push every bit out, so the result is naturally zero.
  assign op = ip << mag;
endmodule

module shift_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [10:0] req0_ip,
  input  logic [4:0]  req0_mag,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [10:0] req1_ip,
  input  logic [4:0]  req1_mag,
  output logic        req1_ready,
  output logic        res_valid,
  output logic [10:0] res_op,
  output logic        res_id,
  input  logic        res_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t      state_reg;
  state_t      state_next;
  logic        last_grant;
  logic        can_accept;
  logic        tie_pick0;
  logic        grant0;
  logic        grant1;
  logic        grant_any;
  logic [10:0] shift_ip;
  logic [4:0]  shift_mag;
  logic [10:0] shift_op;

  // Readies are forced low while reset is asserted so nothing is handed over then.
  assign can_accept = rst_n && ((state_reg == EMPTY) || res_ready);

`ifdef SHIFT_ARB_ROUND_ROBIN_EN
  assign tie_pick0 = last_grant;
`else
  // Fixed priority: last_grant is tracked but cannot influence the tie break.
  assign tie_pick0 = 1'b1 | last_grant;
`endif

  assign grant0    = can_accept && req0_valid && (!req1_valid || tie_pick0);
  assign grant1    = can_accept && req1_valid && (!req0_valid || !tie_pick0);
  assign grant_any = grant0 || grant1;

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    shift_ip  = 11'd0;
    shift_mag = 5'd0;
    if (grant0) begin
      shift_ip  = req0_ip;
      shift_mag = req0_mag;
    end else if (grant1) begin
      shift_ip  = req1_ip;
      shift_mag = req1_mag;
    end
  end

  barrelShifter u_shifter (
    .ip  (shift_ip),
    .mag (shift_mag),
    .op  (shift_op)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY: if (grant_any) state_next = FULL;
      FULL: begin
        if (grant_any)      state_next = FULL;
        else if (res_ready) state_next = EMPTY;
      end
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    res_valid = (state_reg == FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_op     <= 11'd0;
      res_id     <= 1'b0;
      last_grant <= 1'b1;
    end else if (grant_any) begin
      res_op     <= shift_op;
      res_id     <= grant1;
      last_grant <= grant1;
    end
  end

endmodule
